// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Holds the FSM state enum, the per-register control bundle and the in-RUN priority function.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_MDU_WAIT,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED
    } pipe_ctrl_state_e;

    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int MDU_TMO_DEF      = 64;
    localparam int CNT_W_DEF        = 32;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic bubble_mem;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_IDLE      = pipe_ctrl_t'(7'b0000000);
    localparam pipe_ctrl_t CTRL_ALL_STALL = pipe_ctrl_t'(7'b1111000);
    localparam pipe_ctrl_t CTRL_MDU       = pipe_ctrl_t'(7'b1110001);

    // Normal-flow priority once any data-memory wait has been excluded.
    function automatic pipe_ctrl_t run_ctrl(input logic mdu_start,
                                            input logic redirect,
                                            input logic load_use,
                                            input logic jal);
        pipe_ctrl_t c;
        c = CTRL_IDLE;
        if (mdu_start) begin
            c = CTRL_MDU;
        end else if (redirect) begin
            c.flush_id = 1'b1;
            c.flush_ex = 1'b1;
        end else if (load_use) begin
            c.stall_if = 1'b1;
            c.stall_id = 1'b1;
            c.flush_ex = 1'b1;
        end else if (jal) begin
            c.flush_id = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running enable counter that wraps modulo 2^CNT_W.
// Used for the optional pipeline performance counters.
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o <= '0;
        end else if (en) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: merges hazards, redirects, MDU/memory waits and debug halt.
// Optional build macro PIPE_PERF_EN adds stall_cyc_o / flush_cnt_o performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int MDU_TMO      = MDU_TMO_DEF
`ifdef PIPE_PERF_EN
    ,
    parameter int CNT_W        = CNT_W_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_use_i,
    input  logic branch_taken_i,
    input  logic jalr_ex_i,
    input  logic jal_id_i,
    input  logic mdu_start_i,
    input  logic mdu_done_i,
    input  logic dmem_req_i,
    input  logic dmem_ready_i,
    input  logic halt_req_i,
    input  logic resume_i,
    output logic stall_if_o,
    output logic stall_id_o,
    output logic stall_ex_o,
    output logic stall_mem_o,
    output logic flush_id_o,
    output logic flush_ex_o,
    output logic bubble_mem_o,
    output logic halted_o,
    output logic mdu_tmo_o
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cyc_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int TMO_W = $clog2(MDU_TMO + 1);
    localparam int DC_W  = $clog2(DRAIN_CYCLES + 1);

    pipe_ctrl_state_e state_reg, state_next;
    logic [DC_W-1:0]  drain_cnt_reg, drain_cnt_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             tmo_reg;
    logic             mdu_busy_reg, mdu_busy_next;
    logic             tmo_hit;
    logic             halted;
    logic             redirect;
    logic             mem_stall;
    pipe_ctrl_t       ctrl;

    assign redirect  = branch_taken_i | jalr_ex_i;
    assign mem_stall = dmem_req_i & ~dmem_ready_i;
    assign tmo_hit   = (state_reg == ST_MDU_WAIT) && (tmo_cnt_reg == TMO_W'(MDU_TMO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            drain_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            tmo_reg       <= 1'b0;
            mdu_busy_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            tmo_reg       <= tmo_reg | tmo_hit;
            mdu_busy_reg  <= mdu_busy_next;
        end
    end

    always_comb begin
        ctrl           = CTRL_IDLE;
        halted         = 1'b0;
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        mdu_busy_next  = mdu_busy_reg;
        unique case (state_reg)
            ST_RUN: begin
                ctrl = run_ctrl(mdu_start_i, redirect, load_use_i, jal_id_i);
                if (mem_stall) begin
                    ctrl       = CTRL_ALL_STALL;
                    state_next = ST_MEM_WAIT;
                end else if (mdu_start_i) begin
                    state_next   = ST_MDU_WAIT;
                    tmo_cnt_next = '0;
                end else if (ctrl == CTRL_IDLE && halt_req_i) begin
                    // Halt is lowest priority: it only starts on an otherwise quiet cycle.
                    state_next = ST_DRAIN;
                end
            end
            ST_MEM_WAIT: begin
                if (!dmem_ready_i) begin
                    ctrl = CTRL_ALL_STALL;
                end else begin
                    ctrl       = run_ctrl(mdu_start_i, redirect, load_use_i, jal_id_i);
                    state_next = ST_RUN;
                end
            end
            ST_MDU_WAIT: begin
                if (tmo_cnt_reg != TMO_W'(MDU_TMO)) begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
                if (mem_stall) begin
                    ctrl           = CTRL_MDU;
                    ctrl.stall_mem = 1'b1;
                end else if (mdu_done_i) begin
                    state_next = ST_RUN;
                end else begin
                    ctrl = CTRL_MDU;
                end
            end
            ST_DRAIN: begin
                // An MDU op caught mid-drain is tracked locally so the halt is never lost.
                if (mem_stall) begin
                    ctrl          = CTRL_ALL_STALL;
                    mdu_busy_next = (mdu_busy_reg | mdu_start_i) & ~mdu_done_i;
                end else if ((mdu_start_i | mdu_busy_reg) && !mdu_done_i) begin
                    ctrl          = CTRL_MDU;
                    mdu_busy_next = 1'b1;
                end else begin
                    mdu_busy_next = 1'b0;
                    ctrl.stall_if = 1'b1;
                    ctrl.flush_id = 1'b1;
                    if (redirect) begin
                        ctrl.flush_ex = 1'b1;
                    end else if (drain_cnt_reg == DC_W'(DRAIN_CYCLES - 1)) begin
                        state_next     = ST_HALTED;
                        drain_cnt_next = '0;
                    end else begin
                        drain_cnt_next = drain_cnt_reg + DC_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                ctrl   = CTRL_ALL_STALL;
                halted = 1'b1;
                if (resume_i) begin
                    state_next     = ST_RUN;
                    drain_cnt_next = '0;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Outputs are combinational; gating with rst_n forces them low the moment reset asserts.
    assign stall_if_o   = rst_n & ctrl.stall_if;
    assign stall_id_o   = rst_n & ctrl.stall_id;
    assign stall_ex_o   = rst_n & ctrl.stall_ex;
    assign stall_mem_o  = rst_n & ctrl.stall_mem;
    assign flush_id_o   = rst_n & ctrl.flush_id;
    assign flush_ex_o   = rst_n & ctrl.flush_ex;
    assign bubble_mem_o = rst_n & ctrl.bubble_mem;
    assign halted_o     = rst_n & halted;
    assign mdu_tmo_o    = rst_n & (tmo_reg | tmo_hit);

`ifdef PIPE_PERF_EN
    logic [1:0]       perf_en;
    logic [CNT_W-1:0] perf_cnt [2];

    // flush_id together with flush_ex only ever comes from an honoured redirect.
    assign perf_en[0] = stall_if_o & (state_reg != ST_HALTED);
    assign perf_en[1] = flush_id_o & flush_ex_o;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (perf_en[gi]),
                .cnt_o (perf_cnt[gi])
            );
        end
    endgenerate

    assign stall_cyc_o = perf_cnt[0];
    assign flush_cnt_o = perf_cnt[1];
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: behavioural model checked every cycle plus pinned literals.
// Builds with or without PIPE_PERF_EN.
module tb_pipeline_ctrl;

    localparam int DRAIN_CYCLES = 3;
    localparam int MDU_TMO      = 4;

    // Stimulus bits: {load_use, branch, jalr, jal, mdu_start, mdu_done, dmem_req, dmem_ready, halt_req, resume}
    localparam logic [9:0] I_NONE = 10'b0000000000;
    localparam logic [9:0] I_LU   = 10'b1000000000;
    localparam logic [9:0] I_BR   = 10'b0100000000;
    localparam logic [9:0] I_JALR = 10'b0010000000;
    localparam logic [9:0] I_JAL  = 10'b0001000000;
    localparam logic [9:0] I_MS   = 10'b0000100000;
    localparam logic [9:0] I_MD   = 10'b0000010000;
    localparam logic [9:0] I_REQ  = 10'b0000001000;
    localparam logic [9:0] I_RDY  = 10'b0000000100;
    localparam logic [9:0] I_HR   = 10'b0000000010;
    localparam logic [9:0] I_RS   = 10'b0000000001;

    // Observed bits: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_mem, halted, mdu_tmo}
    localparam logic [8:0] O_SIF  = 9'b100000000;
    localparam logic [8:0] O_SID  = 9'b010000000;
    localparam logic [8:0] O_SEX  = 9'b001000000;
    localparam logic [8:0] O_SMEM = 9'b000100000;
    localparam logic [8:0] O_FID  = 9'b000010000;
    localparam logic [8:0] O_FEX  = 9'b000001000;
    localparam logic [8:0] O_BUB  = 9'b000000100;
    localparam logic [8:0] O_HLT  = 9'b000000010;
    localparam logic [8:0] O_TMO  = 9'b000000001;
    localparam logic [8:0] O_ST4  = O_SIF | O_SID | O_SEX | O_SMEM;
    localparam logic [8:0] O_MDU  = O_SIF | O_SID | O_SEX | O_BUB;

    logic clk = 1'b0;
    logic rst_n;
    logic load_use_i, branch_taken_i, jalr_ex_i, jal_id_i, mdu_start_i, mdu_done_i;
    logic dmem_req_i, dmem_ready_i, halt_req_i, resume_i;
    logic stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_id_o, flush_ex_o;
    logic bubble_mem_o, halted_o, mdu_tmo_o;
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cyc_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .MDU_TMO      (MDU_TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_use_i     (load_use_i),
        .branch_taken_i (branch_taken_i),
        .jalr_ex_i      (jalr_ex_i),
        .jal_id_i       (jal_id_i),
        .mdu_start_i    (mdu_start_i),
        .mdu_done_i     (mdu_done_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_ready_i   (dmem_ready_i),
        .halt_req_i     (halt_req_i),
        .resume_i       (resume_i),
        .stall_if_o     (stall_if_o),
        .stall_id_o     (stall_id_o),
        .stall_ex_o     (stall_ex_o),
        .stall_mem_o    (stall_mem_o),
        .flush_id_o     (flush_id_o),
        .flush_ex_o     (flush_ex_o),
        .bubble_mem_o   (bubble_mem_o),
        .halted_o       (halted_o),
        .mdu_tmo_o      (mdu_tmo_o)
`ifdef PIPE_PERF_EN
        ,
        .stall_cyc_o    (stall_cyc_o),
        .flush_cnt_o    (flush_cnt_o)
`endif
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic       lit_on = 1'b0;
    logic [8:0] lit_exp = '0;
    string      lit_name = "";
    logic [8:0] exp_o, act_o;

    // Model state: plain flags and counters describing what the pipeline is waiting on.
    bit          m_mem_wait, m_mdu_wait, m_halted, m_tmo, m_dbusy, m_redir;
    int          m_drain_left, m_mdu_age;
    logic [31:0] m_stall_cyc, m_flush_cnt;

    task automatic model_reset();
        m_mem_wait = 0; m_mdu_wait = 0; m_halted = 0; m_tmo = 0; m_dbusy = 0; m_redir = 0;
        m_drain_left = 0; m_mdu_age = 0; m_stall_cyc = '0; m_flush_cnt = '0;
    endtask

    task automatic model_eval(output logic [8:0] e);
        logic redirect, mstall, was_mem, hlt, tmo_now;
        logic [8:0] c;
        redirect = branch_taken_i | jalr_ex_i;
        mstall   = dmem_req_i & ~dmem_ready_i;
        c = '0; hlt = 0; tmo_now = 0; m_redir = 0;
        if (m_halted) begin
            c = O_ST4; hlt = 1;
            if (resume_i) m_halted = 0;
        end else if (m_drain_left > 0) begin
            if (mstall) begin
                c = O_ST4;
                m_dbusy = (m_dbusy | mdu_start_i) & ~mdu_done_i;
            end else if ((mdu_start_i || m_dbusy) && !mdu_done_i) begin
                c = O_MDU; m_dbusy = 1;
            end else begin
                m_dbusy = 0;
                c = O_SIF | O_FID;
                if (redirect) begin
                    c = c | O_FEX; m_redir = 1;
                end else begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_halted = 1;
                end
            end
        end else if (m_mdu_wait) begin
            tmo_now = (m_mdu_age >= MDU_TMO);
            if (mstall) c = O_MDU | O_SMEM;
            else if (mdu_done_i) m_mdu_wait = 0;
            else c = O_MDU;
            m_mdu_age++;
        end else begin
            was_mem = m_mem_wait;
            if (was_mem ? !dmem_ready_i : mstall) begin
                c = O_ST4; m_mem_wait = 1;
            end else begin
                m_mem_wait = 0;
                if (mdu_start_i) begin
                    c = O_MDU;
                    if (!was_mem) begin m_mdu_wait = 1; m_mdu_age = 0; end
                end else if (redirect) begin
                    c = O_FID | O_FEX; m_redir = 1;
                end else if (load_use_i) begin
                    c = O_SIF | O_SID | O_FEX;
                end else if (jal_id_i) begin
                    c = O_FID;
                end else if (halt_req_i && !was_mem) begin
                    m_drain_left = DRAIN_CYCLES;
                end
            end
        end
        m_tmo = m_tmo | tmo_now;
        e = c | (hlt ? O_HLT : 9'b0) | (m_tmo ? O_TMO : 9'b0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_reset();
            exp_o = '0;
        end else begin
            model_eval(exp_o);
        end
        act_o = {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_id_o, flush_ex_o,
                 bubble_mem_o, halted_o, mdu_tmo_o};
        n_checks++;
        if (act_o !== exp_o) begin
            n_errors++;
            $display("FAIL model cyc=%0d outputs actual=%b required=%b", cyc, act_o, exp_o);
        end
        if (lit_on) begin
            n_checks++;
            if (act_o !== lit_exp) begin
                n_errors++;
                $display("FAIL lit_%s cyc=%0d outputs actual=%b required=%b", lit_name, cyc, act_o, lit_exp);
            end
        end
`ifdef PIPE_PERF_EN
        n_checks++;
        if (stall_cyc_o !== m_stall_cyc || flush_cnt_o !== m_flush_cnt) begin
            n_errors++;
            $display("FAIL perf cyc=%0d stall_cyc=%0d flush_cnt=%0d required %0d %0d",
                     cyc, stall_cyc_o, flush_cnt_o, m_stall_cyc, m_flush_cnt);
        end
        if (rst_n) begin
            if (exp_o[8] && !exp_o[1]) m_stall_cyc = m_stall_cyc + 32'd1;
            if (m_redir) m_flush_cnt = m_flush_cnt + 32'd1;
        end
`endif
        $display("cyc=%0d rst_n=%b in=%b out=%b exp=%b", cyc, rst_n,
                 {load_use_i, branch_taken_i, jalr_ex_i, jal_id_i, mdu_start_i, mdu_done_i,
                  dmem_req_i, dmem_ready_i, halt_req_i, resume_i}, act_o, exp_o);
    end

    task automatic step(input logic [9:0] v, input int n, input logic [8:0] e, input string nm);
        for (int k = 0; k < n; k++) begin
            {load_use_i, branch_taken_i, jalr_ex_i, jal_id_i, mdu_start_i, mdu_done_i,
             dmem_req_i, dmem_ready_i, halt_req_i, resume_i} = v;
            lit_exp  = e;
            lit_name = nm;
            lit_on   = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // Reset asserts mid-cycle with inputs left as they were, so outputs must drop before any edge.
    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        lit_exp  = '0;
        lit_name = "reset";
        lit_on   = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        {load_use_i, branch_taken_i, jalr_ex_i, jal_id_i, mdu_start_i, mdu_done_i,
         dmem_req_i, dmem_ready_i, halt_req_i, resume_i} = I_NONE;
        lit_on = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        {load_use_i, branch_taken_i, jalr_ex_i, jal_id_i, mdu_start_i, mdu_done_i,
         dmem_req_i, dmem_ready_i, halt_req_i, resume_i} = I_NONE;
        @(posedge clk); #1;
        do_reset(2);

        // T1 load-use alone
        step(I_LU, 1, O_SIF | O_SID | O_FEX, "t1_load_use");
        step(I_NONE, 1, 9'b0, "t1_after");
        // T2 redirects override load-use; JAL flushes IF/ID only
        step(I_LU | I_BR, 1, O_FID | O_FEX, "t2_branch_lu");
        step(I_LU | I_JALR, 1, O_FID | O_FEX, "t2_jalr_lu");
        step(I_JAL, 1, O_FID, "t2_jal");
        // T3 memory wait three cycles then release
        step(I_REQ, 3, O_ST4, "t3_mem_wait");
        step(I_REQ | I_RDY, 1, 9'b0, "t3_release");
        step(I_NONE, 1, 9'b0, "t3_after");
        step(I_REQ, 1, O_ST4, "t3_mem_wait2");
        step(I_REQ | I_RDY | I_BR, 1, O_FID | O_FEX, "t3_release_branch");
        // T4 MDU with done, MDU under a memory stall, then timeout
        step(I_MS, 1, O_MDU, "t4_start");
        step(I_NONE, 2, O_MDU, "t4_wait");
        step(I_MD, 1, 9'b0, "t4_done");
        step(I_MS, 1, O_MDU, "t4_start2");
        step(I_REQ, 1, O_MDU | O_SMEM, "t4_mem_in_mdu");
        step(I_MD, 1, 9'b0, "t4_done2");
        step(I_MS, 1, O_MDU, "t4_start3");
        step(I_NONE, MDU_TMO, O_MDU, "t4_pre_tmo");
        step(I_NONE, 1, O_MDU | O_TMO, "t4_tmo");
        step(I_MD, 1, O_TMO, "t4_done_tmo");
        step(I_NONE, 1, O_TMO, "t4_tmo_sticky");
        // T5 halt pulse, drain, halted, resume
        step(I_HR, 1, O_TMO, "t5_halt_req");
        step(I_NONE, DRAIN_CYCLES, O_SIF | O_FID | O_TMO, "t5_drain");
        step(I_NONE, 2, O_ST4 | O_HLT | O_TMO, "t5_halted");
        step(I_RS, 1, O_ST4 | O_HLT | O_TMO, "t5_resume");
        step(I_NONE, 1, O_TMO, "t5_run");
        // Drain with redirect and memory wait freezing the count
        step(I_HR, 1, O_TMO, "d_halt_req");
        step(I_BR, 1, O_SIF | O_FID | O_FEX | O_TMO, "d_redirect");
        step(I_REQ, 1, O_ST4 | O_TMO, "d_mem_wait");
        step(I_NONE, DRAIN_CYCLES, O_SIF | O_FID | O_TMO, "d_drain");
        step(I_NONE, 1, O_ST4 | O_HLT | O_TMO, "d_halted");
        // Resume with halt still high re-enters drain; MDU op mid-drain freezes it
        step(I_HR | I_RS, 1, O_ST4 | O_HLT | O_TMO, "d_resume_hr");
        step(I_HR, 1, O_TMO, "d_rehalt");
        step(I_NONE, 1, O_SIF | O_FID | O_TMO, "d_drain1");
        step(I_MS, 1, O_MDU | O_TMO, "d_mdu_start");
        step(I_NONE, 1, O_MDU | O_TMO, "d_mdu_busy");
        step(I_MD, 1, O_SIF | O_FID | O_TMO, "d_mdu_done");
        step(I_NONE, 1, O_SIF | O_FID | O_TMO, "d_drain3");
        step(I_NONE, 1, O_ST4 | O_HLT | O_TMO, "d_halted2");
        // T6 reset while HALTED and while in MDU_WAIT
        do_reset(2);
        step(I_NONE, 1, 9'b0, "t6_after_halt_reset");
        step(I_MS, 1, O_MDU, "t6_start");
        step(I_NONE, 1, O_MDU, "t6_wait");
        do_reset(1);
        step(I_NONE, 1, 9'b0, "t6_after_mdu_reset");

        lit_on = 1'b0;
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
